// File: rtl/fx2_fifo_master.sv
// fx2_fifo_master: FPGA-side master for the FX2 slave-FIFO interface.
// Drains the OUT endpoint into rx_*, fills the IN endpoint from tx_*, and shares the FIFO bus between them.
`timescale 1ns/1ps
module fx2_fifo_master #(
    parameter logic [1:0] OUT_ADR  = 2'b00,
    parameter logic [1:0] IN_ADR   = 2'b10,
    parameter int         PKT_SIZE = 512,
    parameter int         BURST    = 64
) (
    input  logic       ifclk,
    input  logic       reset_n,
    output logic [1:0] fifoadr,
    input  logic [7:0] fd_in,
    output logic [7:0] fd_out,
    output logic       fd_oe,
    output logic       sloe,
    output logic       slrd,
    output logic       slwr,
    output logic       pktend,
    input  logic       out_empty,
    input  logic       in_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_flush
);
    localparam int PKT_W   = $clog2(PKT_SIZE);
    localparam int BURST_W = $clog2(BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SEL,
        S_RD,
        S_WR_SEL,
        S_WR,
        S_PKTEND
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_fifoadr;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [PKT_W-1:0]   r_pkt_cnt;
    logic [3:0]         r_poll_cnt;
    logic               r_rd_hint;
    logic               r_last_was_wr;

    logic [7:0]         r_skid_mem [2];
    logic               r_skid_wptr;
    logic               r_skid_rptr;
    logic [1:0]         r_skid_cnt;

    logic               w_burst_ok;
    logic               w_skid_room;
    logic               w_rx_pop;
    logic               w_rd_pend;
    logic               w_wr_pend;
    logic               w_rd_go;
    logic               w_wr_go;
    logic               w_flush_go;

    assign w_burst_ok  = r_burst_cnt < BURST_W'(BURST);
    // A full skid buffer still has room when the sink drains an entry this cycle.
    assign w_skid_room = (r_skid_cnt != 2'd2) || rx_ready;
    assign rx_valid    = r_skid_cnt != 2'd0;
    assign rx_data     = r_skid_mem[r_skid_rptr];
    assign w_rx_pop    = rx_valid && rx_ready;

    // Skip read visits that could not move a byte because the skid buffer is full.
    assign w_rd_pend  = (r_rd_hint || (&r_poll_cnt)) && (r_skid_cnt != 2'd2);
    assign w_wr_pend  = tx_valid || (tx_flush && (r_pkt_cnt != '0));
    assign w_rd_go    = !out_empty && w_skid_room && w_burst_ok;
    assign w_wr_go    = tx_valid && !in_full && w_burst_ok;
    assign w_flush_go = !tx_valid && tx_flush && (r_pkt_cnt != '0);

    assign fifoadr  = r_fifoadr;
    assign tx_ready = slwr;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        sloe   = 1'b0;
        fd_oe  = 1'b0;
        slrd   = 1'b0;
        slwr   = 1'b0;
        pktend = 1'b0;
        fd_out = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_rd_pend && w_wr_pend) begin
                    w_next = r_last_was_wr ? S_RD_SEL : S_WR_SEL;
                end else if (w_rd_pend) begin
                    w_next = S_RD_SEL;
                end else if (w_wr_pend) begin
                    w_next = S_WR_SEL;
                end
            end
            S_RD_SEL: begin
                sloe   = 1'b1;
                w_next = S_RD;
            end
            S_RD: begin
                sloe = 1'b1;
                slrd = w_rd_go;
                if (!w_rd_go) begin
                    w_next = S_IDLE;
                end
            end
            S_WR_SEL: begin
                fd_oe  = 1'b1;
                w_next = S_WR;
            end
            S_WR: begin
                fd_oe  = 1'b1;
                fd_out = tx_data;
                slwr   = w_wr_go;
                if (w_flush_go) begin
                    w_next = S_PKTEND;
                end else if (!w_wr_go) begin
                    w_next = S_IDLE;
                end
            end
            S_PKTEND: begin
                pktend = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ifclk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_fifoadr     <= OUT_ADR;
            r_burst_cnt   <= '0;
            r_pkt_cnt     <= '0;
            r_poll_cnt    <= 4'd0;
            r_rd_hint     <= 1'b0;
            r_last_was_wr <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_poll_cnt <= r_poll_cnt + 4'd1;

            if (r_fifoadr == OUT_ADR) begin
                r_rd_hint <= !out_empty;
            end

            if (r_state == S_IDLE) begin
                r_burst_cnt <= '0;
                if (w_next == S_RD_SEL) begin
                    r_fifoadr     <= OUT_ADR;
                    r_last_was_wr <= 1'b0;
                end else if (w_next == S_WR_SEL) begin
                    r_fifoadr     <= IN_ADR;
                    r_last_was_wr <= 1'b1;
                end
            end else if (slrd || slwr) begin
                r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            end

            // The count is log2(PKT_SIZE) bits wide, so a full packet wraps it to zero.
            if (r_state == S_PKTEND) begin
                r_pkt_cnt <= '0;
            end else if (slwr) begin
                r_pkt_cnt <= r_pkt_cnt + PKT_W'(1);
            end
        end
    end

    // NOTE: the skid storage is not reset; the reset count marks its contents invalid.
    always_ff @(posedge ifclk) begin
        if (slrd) begin
            r_skid_mem[r_skid_wptr] <= fd_in;
        end
    end

    always_ff @(posedge ifclk) begin
        if (!reset_n) begin
            r_skid_wptr <= 1'b0;
            r_skid_rptr <= 1'b0;
            r_skid_cnt  <= 2'd0;
        end else begin
            if (slrd) begin
                r_skid_wptr <= !r_skid_wptr;
            end
            if (w_rx_pop) begin
                r_skid_rptr <= !r_skid_rptr;
            end
            case ({slrd, w_rx_pop})
                2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
                2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
                default: r_skid_cnt <= r_skid_cnt;
            endcase
        end
    end

endmodule
